// File: rtl/tlb_miss_handler.sv
// Hardware page-table walker servicing instruction and data TLB misses.
// Ports:
//   clk, reset (sync, active-high)
//   itlb_miss/itlb_vaddr, dtlb_miss/dtlb_vaddr : miss requests (data wins)
//   ptbr : page-table base
//   mem_req/mem_addr/mem_ack/mem_rdata : PTE read port
//   itlb_write/dtlb_write/tlb_vaddr/tlb_paddr_new : TLB fill
//   stall : pipeline hold
//   page_fault/fault_is_data : invalid-PTE report
module tlb_miss_handler #(
  parameter int VADDR_W   = 20,
  parameter int PADDR_W   = 20,
  parameter int PAGE_BITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               itlb_miss,
  input  logic [VADDR_W-1:0] itlb_vaddr,
  input  logic               dtlb_miss,
  input  logic [VADDR_W-1:0] dtlb_vaddr,
  input  logic [PADDR_W-1:0] ptbr,
  output logic               mem_req,
  output logic [PADDR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic               itlb_write,
  output logic               dtlb_write,
  output logic [VADDR_W-1:0] tlb_vaddr,
  output logic [PADDR_W-1:0] tlb_paddr_new,
  output logic               stall,
  output logic               page_fault,
  output logic               fault_is_data
);

  localparam int PPN_W = PADDR_W - PAGE_BITS;
  localparam int VPN_W = VADDR_W - PAGE_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [VADDR_W-1:0] vaddr_q, vaddr_d;
  logic [PPN_W-1:0]   ppn_q, ppn_d;
  logic               src_q, src_d;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic               fid_q, fid_d;

  logic [VPN_W+1:0]   vpn_x4;
  logic [PADDR_W-1:0] walk_addr;

  // Only the valid bit and the PPN field of the PTE carry meaning.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[30:PPN_W];

  // PTE address wraps within the physical address space.
  assign vpn_x4    = {vaddr_q[VADDR_W-1:PAGE_BITS], 2'b00};
  assign walk_addr = ptbr + PADDR_W'(vpn_x4);

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    ppn_d   = ppn_q;
    src_d   = src_q;
    addr_d  = addr_q;
    fid_d   = fid_q;
    unique case (state_q)
      S_IDLE: begin
        if (dtlb_miss) begin
          vaddr_d = dtlb_vaddr;
          src_d   = 1'b1;
          state_d = S_REQ;
        end else if (itlb_miss) begin
          vaddr_d = itlb_vaddr;
          src_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Freeze the address so later ptbr changes cannot disturb it.
        addr_d  = walk_addr;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) begin
          ppn_d = mem_rdata[PPN_W-1:0];
          if (mem_rdata[31]) begin
            state_d = S_FILL;
          end else begin
            fid_d   = src_q;
            state_d = S_FAULT;
          end
        end
      end
      S_FILL:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vaddr_q <= '0;
      ppn_q   <= '0;
      src_q   <= 1'b0;
      addr_q  <= '0;
      fid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      ppn_q   <= ppn_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      fid_q   <= fid_d;
    end
  end

  assign mem_req       = (state_q == S_REQ);
  assign mem_addr      = mem_req ? walk_addr : addr_q;
  assign itlb_write    = (state_q == S_FILL) && !src_q;
  assign dtlb_write    = (state_q == S_FILL) && src_q;
  assign tlb_vaddr     = vaddr_q;
  assign tlb_paddr_new = {ppn_q, {PAGE_BITS{1'b0}}};
  assign page_fault    = (state_q == S_FAULT);
  assign fault_is_data = fid_q;
  assign stall         = (state_q != S_IDLE) || itlb_miss || dtlb_miss;

endmodule

// File: tb/tb_tlb_miss_handler.sv
// Directed bench for tlb_miss_handler: per-cycle vector table plus
// a hand sequence for reset aborting a walk.
module tb_tlb_miss_handler;

  logic        clk = 1'b0;
  logic        reset;
  logic        itlb_miss, dtlb_miss;
  logic [19:0] itlb_vaddr, dtlb_vaddr, ptbr;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        itlb_write, dtlb_write;
  logic [19:0] tlb_vaddr, tlb_paddr_new;
  logic        stall, page_fault, fault_is_data;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tlb_miss_handler dut (
    .clk(clk), .reset(reset),
    .itlb_miss(itlb_miss), .itlb_vaddr(itlb_vaddr),
    .dtlb_miss(dtlb_miss), .dtlb_vaddr(dtlb_vaddr),
    .ptbr(ptbr),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .itlb_write(itlb_write), .dtlb_write(dtlb_write),
    .tlb_vaddr(tlb_vaddr), .tlb_paddr_new(tlb_paddr_new),
    .stall(stall), .page_fault(page_fault),
    .fault_is_data(fault_is_data)
  );

  typedef struct {
    logic        rst, im;
    logic [19:0] iva;
    logic        dm;
    logic [19:0] dva, pt;
    logic        ack;
    logic [31:0] rd;
    logic        ca, req;
    logic [19:0] addr;
    logic        iw, dw;
    logic [19:0] tv, tp;
    logic        st, pf, fid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic rst, input logic im, input logic [19:0] iva,
    input logic dm, input logic [19:0] dva, input logic [19:0] pt,
    input logic ack, input logic [31:0] rd,
    input logic ca, input logic req, input logic [19:0] addr,
    input logic iw, input logic dw,
    input logic [19:0] tv, input logic [19:0] tp,
    input logic st, input logic pf, input logic fid);
    vec_t v;
    v.rst = rst; v.im = im; v.iva = iva; v.dm = dm; v.dva = dva;
    v.pt = pt; v.ack = ack; v.rd = rd; v.ca = ca; v.req = req;
    v.addr = addr; v.iw = iw; v.dw = dw; v.tv = tv; v.tp = tp;
    v.st = st; v.pf = pf; v.fid = fid;
    tbl.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  localparam logic [19:0] P = 20'h08000;
  localparam logic [19:0] W = 20'hFFFFC;
  localparam logic [19:0] N = 20'h12340;

  initial begin
    reset = 1'b1; itlb_miss = 0; dtlb_miss = 0;
    itlb_vaddr = '0; dtlb_vaddr = '0; ptbr = P;
    mem_ack = 0; mem_rdata = '0;

    // single data walk, miss dropped after REQ
    add(1,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            0,0,0);
    add(0,0,0,      1,'h03ABC,P,0,0,           0,0,0,      0,0,0,0,            1,0,0);
    add(0,0,0,      0,'h03ABC,P,0,0,           1,1,'h0800C,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      P,0,0,           1,0,'h0800C,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      P,1,'h80000055,  1,0,'h0800C,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,1,'h03ABC,'h55000,1,0,0);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            0,0,0);
    // simultaneous misses: data first
    add(0,1,'h05123,1,'h07FFF,P,0,0,           0,0,0,      0,0,0,0,            1,0,0);
    add(0,1,'h05123,1,'h07FFF,P,0,0,           1,1,'h0801C,0,0,0,0,            1,0,0);
    add(0,1,'h05123,1,'h07FFF,P,1,'h800000A1,  1,0,'h0801C,0,0,0,0,            1,0,0);
    add(0,1,'h05123,0,0,      P,0,0,           0,0,0,      0,1,'h07FFF,'hA1000,1,0,0);
    add(0,1,'h05123,0,0,      P,0,0,           0,0,0,      0,0,0,0,            1,0,0);
    add(0,1,'h05123,0,0,      P,0,0,           1,1,'h08014,0,0,0,0,            1,0,0);
    add(0,1,'h05123,0,0,      P,1,'h800000B2,  1,0,'h08014,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      1,0,'h05123,'hB2000,1,0,0);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            0,0,0);
    // data fault then instruction fault
    add(0,0,0,      1,'h0F000,P,0,0,           0,0,0,      0,0,0,0,            1,0,0);
    add(0,0,0,      1,'h0F000,P,0,0,           1,1,'h0803C,0,0,0,0,            1,0,0);
    add(0,0,0,      1,'h0F000,P,1,'h7FFFFFFF,  1,0,'h0803C,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            1,1,1);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            0,0,1);
    add(0,1,'h01000,0,0,      P,0,0,           0,0,0,      0,0,0,0,            1,0,1);
    add(0,1,'h01000,0,0,      P,0,0,           1,1,'h08004,0,0,0,0,            1,0,1);
    add(0,1,'h01000,0,0,      P,1,'h00000012,  1,0,'h08004,0,0,0,0,            1,0,1);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            1,1,0);
    // stray ack in IDLE
    add(0,0,0,      0,0,      P,1,'h80000099,  0,0,0,      0,0,0,0,            0,0,0);
    add(0,0,0,      0,0,      P,0,0,           0,0,0,      0,0,0,0,            0,0,0);
    // address wrap, long wait, ptbr change mid-walk
    add(0,0,0,      1,'h02345,W,0,0,           0,0,0,      0,0,0,0,            1,0,0);
    add(0,0,0,      1,'h02345,W,0,0,           1,1,'h00004,0,0,0,0,            1,0,0);
    for (int k = 0; k < 10; k++)
      add(0,0,0,    1,'h02345,(k < 2) ? W : N,0,0,
                                               1,0,'h00004,0,0,0,0,            1,0,0);
    add(0,0,0,      1,'h02345,N,1,'h800000FF,  1,0,'h00004,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      N,0,0,           0,0,0,      0,1,'h02345,'hFF000,1,0,0);
    add(0,0,0,      0,0,      N,0,0,           0,0,0,      0,0,0,0,            0,0,0);
    add(0,1,'h0A000,0,0,      N,0,0,           0,0,0,      0,0,0,0,            1,0,0);
    add(0,1,'h0A000,0,0,      N,0,0,           1,1,'h12368,0,0,0,0,            1,0,0);
    add(0,1,'h0A000,0,0,      N,1,'h80000003,  1,0,'h12368,0,0,0,0,            1,0,0);
    add(0,0,0,      0,0,      N,0,0,           0,0,0,      1,0,'h0A000,'h03000,1,0,0);
    add(0,0,0,      0,0,      N,0,0,           0,0,0,      0,0,0,0,            0,0,0);

    tick;
    tick;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      logic ok;
      v = tbl[i];
      reset = v.rst; itlb_miss = v.im; itlb_vaddr = v.iva;
      dtlb_miss = v.dm; dtlb_vaddr = v.dva; ptbr = v.pt;
      mem_ack = v.ack; mem_rdata = v.rd;
      @(negedge clk);
      ok = (mem_req === v.req) &&
           (!v.ca || mem_addr === v.addr) &&
           (itlb_write === v.iw) && (dtlb_write === v.dw) &&
           (!(v.iw || v.dw) ||
            (tlb_vaddr === v.tv && tlb_paddr_new === v.tp)) &&
           (stall === v.st) && (page_fault === v.pf) &&
           (fault_is_data === v.fid);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL row%0d: req=%b addr=%h iw=%b dw=%b tv=%h tp=%h st=%b pf=%b fid=%b expected req=%b addr=%h iw=%b dw=%b tv=%h tp=%h st=%b pf=%b fid=%b",
          i, mem_req, mem_addr, itlb_write, dtlb_write, tlb_vaddr,
          tlb_paddr_new, stall, page_fault, fault_is_data,
          v.req, v.addr, v.iw, v.dw, v.tv, v.tp, v.st, v.pf, v.fid);
      end
      tick;
    end

    // data fault to set fault_is_data, then reset aborts a walk in WAIT
    mem_ack = 0; itlb_miss = 0;
    dtlb_miss = 1; dtlb_vaddr = 20'h0F000;
    tick;
    @(negedge clk);
    chk("flt_req", {31'd0, mem_req}, 32'd1);
    tick;
    dtlb_miss = 0; mem_ack = 1; mem_rdata = 32'h0;
    tick;
    mem_ack = 0;
    @(negedge clk);
    chk("flt_pf", {30'd0, page_fault, fault_is_data}, 32'd3);
    tick;
    dtlb_miss = 1; dtlb_vaddr = 20'h03ABC;
    tick;
    dtlb_miss = 0;
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd1);
    tick;
    reset = 1;
    @(negedge clk);
    chk("rst_wait_stall", {31'd0, stall}, 32'd1);
    tick;
    reset = 0; mem_ack = 1; mem_rdata = 32'h80000077;
    @(negedge clk);
    chk("rst_idle", {28'd0, stall, mem_req, fault_is_data, page_fault},
        32'd0);
    tick;
    mem_ack = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_quiet", {27'd0, itlb_write, dtlb_write, page_fault,
                        mem_req, stall}, 32'd0);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
